// File: rtl/reset_sequencer_if.sv
// rtl/reset_sequencer_if.sv - lock/request inputs and staged reset outputs of reset_sequencer
interface reset_sequencer_if #(
    parameter int N_STAGES = 3
);
    logic                pll_locked;
    logic                sw_reset_req;
    logic [N_STAGES-1:0] stage_resetn;
    logic                busy;
    logic [15:0]         seq_count;
    logic                lock_timeout;

    modport master (
        output pll_locked,
        output sw_reset_req,
        input  stage_resetn,
        input  busy,
        input  seq_count,
        input  lock_timeout
    );

    modport slave (
        input  pll_locked,
        input  sw_reset_req,
        output stage_resetn,
        output busy,
        output seq_count,
        output lock_timeout
    );
endinterface

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staged reset release after PLL lock; lock watchdog under RESET_SEQ_WDT_EN
module reset_sequencer #(
    parameter int N_STAGES     = 3,
    parameter int HOLD_CYCLES  = 16,
    parameter int STAGE_GAP    = 8,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             in_resetn,
    reset_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        ST_ASSERT,
        ST_WAIT_LOCK,
        ST_RELEASE,
        ST_RUN
    } state_t;

    localparam int HC_W  = $clog2(HOLD_CYCLES + 1);
    localparam int GAP_W = $clog2(STAGE_GAP + 1);
    localparam int IDX_W = $clog2(N_STAGES + 1);

    localparam logic [HC_W-1:0]     HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
    localparam logic [GAP_W-1:0]    GAP_LAST  = GAP_W'(STAGE_GAP - 1);
    localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(N_STAGES - 1);
    localparam logic [N_STAGES-1:0] STAGE_ONE = N_STAGES'(1);

    if (N_STAGES < 1 || N_STAGES > 8) begin : g_bad_n_stages
        $error("reset_sequencer: N_STAGES must be 1..8");
    end
    if (HOLD_CYCLES < 2) begin : g_bad_hold
        $error("reset_sequencer: HOLD_CYCLES must be >= 2");
    end
    if (STAGE_GAP < 1) begin : g_bad_gap
        $error("reset_sequencer: STAGE_GAP must be >= 1");
    end
    if (LOCK_TIMEOUT < 1) begin : g_bad_timeout
        $error("reset_sequencer: LOCK_TIMEOUT must be >= 1");
    end

    logic [3:0] rst_sync;
    logic       rst_n;
    logic       lock_meta;
    logic       lock_s;
    logic       abort;

    state_t                state_q, state_d;
    logic [HC_W-1:0]       hold_q, hold_d;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [N_STAGES-1:0]   stage_q, stage_d;
    logic [15:0]           seq_q, seq_d;
    logic                  busy_q, busy_d;

    // Internal reset: synchronizer chain plus the rst_n flop, so rst_n rises on the
    // fourth edge after in_resetn releases while assertion stays asynchronous.
    always_ff @(posedge clk or negedge in_resetn) begin
        if (!in_resetn) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[2:0], 1'b1};
        end
    end

    assign rst_n = rst_sync[3];

    // Two-flop synchronizer for the asynchronous PLL lock indicator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= bus.pll_locked;
            lock_s    <= lock_meta;
        end
    end

    // A request and a lock loss arriving together are one abort, one ASSERT entry.
    assign abort = bus.sw_reset_req || !lock_s;

`ifdef RESET_SEQ_WDT_EN
    localparam int WDT_W = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(LOCK_TIMEOUT - 1);

    logic [WDT_W-1:0] wdt_q, wdt_d;
    logic             lto_q, lto_d;
`endif

    // FSM and datapath registers; everything clears asynchronously with rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ASSERT;
            hold_q  <= '0;
            gap_q   <= '0;
            idx_q   <= '0;
            stage_q <= '0;
            seq_q   <= '0;
            busy_q  <= 1'b1;
`ifdef RESET_SEQ_WDT_EN
            wdt_q   <= '0;
            lto_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            gap_q   <= gap_d;
            idx_q   <= idx_d;
            stage_q <= stage_d;
            seq_q   <= seq_d;
            busy_q  <= busy_d;
`ifdef RESET_SEQ_WDT_EN
            wdt_q   <= wdt_d;
            lto_q   <= lto_d;
`endif
        end
    end

    // Next-state logic: hold, wait for lock, release stages one per gap, then run.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        gap_d   = gap_q;
        idx_d   = idx_q;
        stage_d = stage_q;
        seq_d   = seq_q;
`ifdef RESET_SEQ_WDT_EN
        wdt_d   = '0;
        lto_d   = lto_q;
`endif
        case (state_q)
            ST_ASSERT: begin
                stage_d = '0;
                if (bus.sw_reset_req) begin
                    hold_d = '0;
                end else if (hold_q == HOLD_LAST) begin
                    hold_d  = '0;
                    state_d = ST_WAIT_LOCK;
                end else begin
                    hold_d = hold_q + HC_W'(1);
                end
            end
            ST_WAIT_LOCK: begin
                stage_d = '0;
                if (lock_s) begin
                    state_d = ST_RELEASE;
                    stage_d = STAGE_ONE;
                    gap_d   = '0;
                    idx_d   = '0;
                end
`ifdef RESET_SEQ_WDT_EN
                else if (wdt_q == WDT_LAST) begin
                    lto_d   = 1'b1;
                    hold_d  = '0;
                    state_d = ST_ASSERT;
                end else begin
                    wdt_d = wdt_q + WDT_W'(1);
                end
`endif
            end
            ST_RELEASE: begin
                if (abort) begin
                    state_d = ST_ASSERT;
                    stage_d = '0;
                    hold_d  = '0;
                end else if (idx_q == IDX_LAST) begin
                    state_d = ST_RUN;
                    seq_d   = seq_q + 16'd1;
`ifdef RESET_SEQ_WDT_EN
                    lto_d   = 1'b0;
`endif
                end else if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    idx_d   = idx_q + IDX_W'(1);
                    stage_d = stage_q | (STAGE_ONE << (idx_q + IDX_W'(1)));
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_ASSERT;
                    stage_d = '0;
                    hold_d  = '0;
                end
            end
            default: begin
                state_d = ST_ASSERT;
                stage_d = '0;
                hold_d  = '0;
            end
        endcase
        busy_d = (state_d != ST_RUN);
    end

    assign bus.stage_resetn = stage_q;
    assign bus.busy         = busy_q;
    assign bus.seq_count    = seq_q;
`ifdef RESET_SEQ_WDT_EN
    assign bus.lock_timeout = lto_q;
`else
    assign bus.lock_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - directed bench for reset_sequencer (default parameters)
`timescale 1ns/100ps
module tb_reset_sequencer;
    localparam int N = 3;

    logic clk = 1'b0;
    logic in_resetn = 1'b0;
    int   cyc = 0;
    int   base = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    reset_sequencer_if #(.N_STAGES(N)) bus();

    reset_sequencer #(
        .N_STAGES(N),
        .HOLD_CYCLES(16),
        .STAGE_GAP(8),
        .LOCK_TIMEOUT(1024)
    ) dut (
        .clk(clk),
        .in_resetn(in_resetn),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic at_edge(input int k);
        int guard = 0;
        while (cyc < base + k + 1 && guard < 3000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        n_checks++;
        if (cyc != base + k + 1) begin
            n_fail++;
            $display("FAIL edge_sync: at cycle %0d, wanted edge %0d (cycle %0d)", cyc, k, base + k + 1);
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        in_resetn = 1'b1;
        base = cyc;
    endtask

    task automatic test_reset();
        bus.pll_locked = 1'b1;
        bus.sw_reset_req = 1'b0;
        in_resetn = 1'b0;
        #12;
        n_checks++;
        if (bus.stage_resetn !== 3'b000) begin n_fail++; $display("FAIL reset_stage: got %b want 000", bus.stage_resetn); end
        n_checks++;
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b want 1", bus.busy); end
        n_checks++;
        if (bus.seq_count !== 16'd0) begin n_fail++; $display("FAIL reset_seq: got %0d want 0", bus.seq_count); end
        n_checks++;
        if (bus.lock_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_lto: got %b want 0", bus.lock_timeout); end
    endtask

    task automatic test_power_up();
        int         e[6] = '{19, 20, 27, 28, 35, 36};
        logic [2:0] x[6] = '{3'b000, 3'b001, 3'b001, 3'b011, 3'b011, 3'b111};
        release_reset();
        for (int i = 0; i < 6; i++) begin
            at_edge(e[i]);
            n_checks++;
            if (bus.stage_resetn !== x[i]) begin n_fail++; $display("FAIL powerup_stage@%0d: got %b want %b", e[i], bus.stage_resetn, x[i]); end
            n_checks++;
            if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL powerup_busy@%0d: got %b want 1", e[i], bus.busy); end
        end
        at_edge(37);
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL powerup_run_busy: got %b want 0", bus.busy); end
        n_checks++;
        if (bus.seq_count !== 16'd1) begin n_fail++; $display("FAIL powerup_seq: got %0d want 1", bus.seq_count); end
    endtask

    task automatic test_sw_reset();
        int         e[4] = '{57, 58, 66, 74};
        logic [2:0] x[4] = '{3'b000, 3'b001, 3'b011, 3'b111};
        at_edge(40);
        bus.sw_reset_req = 1'b1;
        at_edge(41);
        bus.sw_reset_req = 1'b0;
        n_checks++;
        if (bus.stage_resetn !== 3'b000) begin n_fail++; $display("FAIL sw_abort_stage: got %b want 000", bus.stage_resetn); end
        n_checks++;
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL sw_abort_busy: got %b want 1", bus.busy); end
        for (int i = 0; i < 4; i++) begin
            at_edge(e[i]);
            n_checks++;
            if (bus.stage_resetn !== x[i]) begin n_fail++; $display("FAIL sw_reseq_stage@%0d: got %b want %b", e[i], bus.stage_resetn, x[i]); end
        end
        at_edge(75);
        n_checks++;
        if (bus.busy !== 1'b0 || bus.seq_count !== 16'd2) begin
            n_fail++; $display("FAIL sw_reseq_run: busy %b seq %0d want busy 0 seq 2", bus.busy, bus.seq_count);
        end
    endtask

    task automatic test_lock_loss();
        at_edge(80);
        bus.sw_reset_req = 1'b1;
        at_edge(81);
        bus.sw_reset_req = 1'b0;
        at_edge(106);
        n_checks++;
        if (bus.stage_resetn !== 3'b011) begin n_fail++; $display("FAIL lockloss_pre@106: got %b want 011", bus.stage_resetn); end
        at_edge(108);
        bus.pll_locked = 1'b0;
        at_edge(110);
        n_checks++;
        if (bus.stage_resetn !== 3'b011) begin n_fail++; $display("FAIL lockloss_sync@110: got %b want 011", bus.stage_resetn); end
        at_edge(111);
        n_checks++;
        if (bus.stage_resetn !== 3'b000 || bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL lockloss_abort@111: stage %b busy %b want 000 1", bus.stage_resetn, bus.busy);
        end
        at_edge(150);
        n_checks++;
        if (bus.stage_resetn !== 3'b000 || bus.busy !== 1'b1 || bus.seq_count !== 16'd2) begin
            n_fail++; $display("FAIL lockloss_wait@150: stage %b busy %b seq %0d want 000 1 2", bus.stage_resetn, bus.busy, bus.seq_count);
        end
        bus.pll_locked = 1'b1;
        at_edge(152);
        n_checks++;
        if (bus.stage_resetn !== 3'b000) begin n_fail++; $display("FAIL relock@152: got %b want 000", bus.stage_resetn); end
        at_edge(153);
        n_checks++;
        if (bus.stage_resetn !== 3'b001) begin n_fail++; $display("FAIL relock@153: got %b want 001", bus.stage_resetn); end
        at_edge(169);
        n_checks++;
        if (bus.stage_resetn !== 3'b111) begin n_fail++; $display("FAIL relock@169: got %b want 111", bus.stage_resetn); end
        at_edge(170);
        n_checks++;
        if (bus.busy !== 1'b0 || bus.seq_count !== 16'd3) begin
            n_fail++; $display("FAIL relock_run@170: busy %b seq %0d want 0 3", bus.busy, bus.seq_count);
        end
    endtask

    task automatic test_simultaneous();
        at_edge(180);
        bus.pll_locked = 1'b0;
        at_edge(182);
        bus.sw_reset_req = 1'b1;
        n_checks++;
        if (bus.stage_resetn !== 3'b111 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL simul_pre@182: stage %b busy %b want 111 0", bus.stage_resetn, bus.busy);
        end
        at_edge(183);
        bus.sw_reset_req = 1'b0;
        n_checks++;
        if (bus.stage_resetn !== 3'b000 || bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL simul_abort@183: stage %b busy %b want 000 1", bus.stage_resetn, bus.busy);
        end
        at_edge(190);
        bus.pll_locked = 1'b1;
        at_edge(199);
        n_checks++;
        if (bus.stage_resetn !== 3'b000) begin n_fail++; $display("FAIL simul_hold@199: got %b want 000", bus.stage_resetn); end
        at_edge(200);
        n_checks++;
        if (bus.stage_resetn !== 3'b001 || bus.seq_count !== 16'd3) begin
            n_fail++; $display("FAIL simul_rel@200: stage %b seq %0d want 001 3", bus.stage_resetn, bus.seq_count);
        end
        at_edge(217);
        n_checks++;
        if (bus.busy !== 1'b0 || bus.seq_count !== 16'd4) begin
            n_fail++; $display("FAIL simul_run@217: busy %b seq %0d want 0 4", bus.busy, bus.seq_count);
        end
    endtask

    task automatic test_sw_in_assert_wait();
        at_edge(220);
        bus.sw_reset_req = 1'b1;
        at_edge(221);
        bus.sw_reset_req = 1'b0;
        at_edge(225);
        bus.sw_reset_req = 1'b1;
        at_edge(226);
        bus.sw_reset_req = 1'b0;
        at_edge(242);
        n_checks++;
        if (bus.stage_resetn !== 3'b000) begin n_fail++; $display("FAIL hold_restart@242: got %b want 000", bus.stage_resetn); end
        bus.sw_reset_req = 1'b1;
        at_edge(243);
        bus.sw_reset_req = 1'b0;
        n_checks++;
        if (bus.stage_resetn !== 3'b001) begin n_fail++; $display("FAIL wait_ignore@243: got %b want 001", bus.stage_resetn); end
        at_edge(259);
        n_checks++;
        if (bus.stage_resetn !== 3'b111) begin n_fail++; $display("FAIL restart_rel@259: got %b want 111", bus.stage_resetn); end
        at_edge(260);
        n_checks++;
        if (bus.busy !== 1'b0 || bus.seq_count !== 16'd5) begin
            n_fail++; $display("FAIL restart_run@260: busy %b seq %0d want 0 5", bus.busy, bus.seq_count);
        end
    endtask

    task automatic test_async_reset();
        int         e[4] = '{19, 20, 28, 36};
        logic [2:0] x[4] = '{3'b000, 3'b001, 3'b011, 3'b111};
        at_edge(265);
        bus.sw_reset_req = 1'b1;
        at_edge(266);
        bus.sw_reset_req = 1'b0;
        at_edge(291);
        n_checks++;
        if (bus.stage_resetn !== 3'b011) begin n_fail++; $display("FAIL async_pre@291: got %b want 011", bus.stage_resetn); end
        at_edge(293);
        #2;
        in_resetn = 1'b0;
        #0.5;
        n_checks++;
        if (bus.stage_resetn !== 3'b000 || bus.busy !== 1'b1 || bus.seq_count !== 16'd0) begin
            n_fail++; $display("FAIL async_clear: stage %b busy %b seq %0d want 000 1 0", bus.stage_resetn, bus.busy, bus.seq_count);
        end
        #0.5;
        in_resetn = 1'b1;
        base = cyc;
        for (int i = 0; i < 4; i++) begin
            at_edge(e[i]);
            n_checks++;
            if (bus.stage_resetn !== x[i]) begin n_fail++; $display("FAIL async_reseq@%0d: got %b want %b", e[i], bus.stage_resetn, x[i]); end
        end
        at_edge(37);
        n_checks++;
        if (bus.busy !== 1'b0 || bus.seq_count !== 16'd1 || bus.lock_timeout !== 1'b0) begin
            n_fail++; $display("FAIL async_run@37: busy %b seq %0d lto %b want 0 1 0", bus.busy, bus.seq_count, bus.lock_timeout);
        end
    endtask

`ifdef RESET_SEQ_WDT_EN
    task automatic test_watchdog();
        in_resetn = 1'b0;
        bus.pll_locked = 1'b0;
        #20;
        release_reset();
        at_edge(1042);
        n_checks++;
        if (bus.lock_timeout !== 1'b0 || bus.stage_resetn !== 3'b000) begin
            n_fail++; $display("FAIL wdt_pre@1042: lto %b stage %b want 0 000", bus.lock_timeout, bus.stage_resetn);
        end
        at_edge(1043);
        n_checks++;
        if (bus.lock_timeout !== 1'b1 || bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL wdt_fire@1043: lto %b busy %b want 1 1", bus.lock_timeout, bus.busy);
        end
        at_edge(1060);
        bus.pll_locked = 1'b1;
        at_edge(1062);
        n_checks++;
        if (bus.stage_resetn !== 3'b000 || bus.lock_timeout !== 1'b1) begin
            n_fail++; $display("FAIL wdt_retry@1062: stage %b lto %b want 000 1", bus.stage_resetn, bus.lock_timeout);
        end
        at_edge(1063);
        n_checks++;
        if (bus.stage_resetn !== 3'b001) begin n_fail++; $display("FAIL wdt_rel@1063: got %b want 001", bus.stage_resetn); end
        at_edge(1079);
        n_checks++;
        if (bus.lock_timeout !== 1'b1 || bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL wdt_sticky@1079: lto %b busy %b want 1 1", bus.lock_timeout, bus.busy);
        end
        at_edge(1080);
        n_checks++;
        if (bus.lock_timeout !== 1'b0 || bus.busy !== 1'b0 || bus.seq_count !== 16'd1) begin
            n_fail++; $display("FAIL wdt_run@1080: lto %b busy %b seq %0d want 0 0 1", bus.lock_timeout, bus.busy, bus.seq_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_power_up();
        test_sw_reset();
        test_lock_loss();
        test_simultaneous();
        test_sw_in_assert_wait();
        test_async_reset();
`ifdef RESET_SEQ_WDT_EN
        test_watchdog();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, limit 200000", $time);
        $fatal(1);
    end
endmodule
